// File: rtl/multi_dataflow_tcdm_responder.sv
// Single-port TCDM slave bank: byte-enabled word scratchpad, fixed 1-cycle response.
// Backpressure: grant is req gated by an optional LFSR stall; a stalled master holds its request.
module multi_dataflow_tcdm_responder #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NB_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [7:0]  STALL_THRESH = 8'd64,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    tcdm_req_i,
  output logic                    tcdm_gnt_o,
  input  logic [31:0]             tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
  output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
  output logic                    tcdm_r_valid_o,
  output logic                    err_o,
  output logic [31:0]             nb_reads_o,
  output logic [31:0]             nb_writes_o
);

  localparam int unsigned BE_W      = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam int unsigned NREP      = (DATA_WIDTH + 31) / 32;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [NREP*32-1:0]    OOR_WIDE = {NREP{32'hDEADBEEF}};
  localparam logic [DATA_WIDTH-1:0] OOR_DATA = OOR_WIDE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem_q [NB_WORDS];

  logic [15:0]           lfsr_q, lfsr_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  err_q, err_d;
  logic [31:0]           nb_reads_q, nb_reads_d;
  logic [31:0]           nb_writes_q, nb_writes_d;

  logic                  stall;
  logic                  gnt;
  logic                  borrow;
  logic [31:0]           offset;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  mem_we;
  logic                  unused_addr_lsb;

  assign stall      = STALL_EN && (lfsr_q[7:0] < STALL_THRESH);
  assign gnt        = tcdm_req_i & ~stall;
  assign tcdm_gnt_o = gnt;

  // The borrow of the 33-bit subtraction flags addresses below the bank base.
  assign {borrow, offset} = {1'b0, tcdm_add_i} - {1'b0, BASE_ADDR};
  assign in_range         = !borrow && ({2'b00, offset[31:2]} < NB_WORDS);
  assign idx              = offset[IDX_W+1:2];
  assign unused_addr_lsb  = ^offset[1:0];

  // Writes land even when clear_i drops their response.
  assign mem_we = gnt & ~tcdm_wen_i & in_range;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (tcdm_be_i[k]) mem_q[idx][k*8 +: 8] <= tcdm_data_i[k*8 +: 8];
      end
    end
  end

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_MASK;
  end

  always_comb begin
    r_valid_d   = 1'b0;
    r_data_d    = r_data_q;
    err_d       = err_q;
    nb_reads_d  = nb_reads_q;
    nb_writes_d = nb_writes_q;
    if (clear_i) begin
      err_d       = 1'b0;
      nb_reads_d  = '0;
      nb_writes_d = '0;
    end else if (gnt) begin
      r_valid_d = 1'b1;
      if (!tcdm_wen_i)   r_data_d = '0;
      else if (in_range) r_data_d = mem_q[idx];
      else               r_data_d = OOR_DATA;
      if (!in_range) err_d = 1'b1;
      if (tcdm_wen_i) nb_reads_d  = nb_reads_q + 32'd1;
      else            nb_writes_d = nb_writes_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q      <= SEED;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      err_q       <= 1'b0;
      nb_reads_q  <= '0;
      nb_writes_q <= '0;
    end else begin
      lfsr_q      <= clear_i ? SEED : lfsr_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      err_q       <= err_d;
      nb_reads_q  <= nb_reads_d;
      nb_writes_q <= nb_writes_d;
    end
  end

  assign tcdm_r_data_o  = r_data_q;
  assign tcdm_r_valid_o = r_valid_q;
  assign err_o          = err_q;
  assign nb_reads_o     = nb_reads_q;
  assign nb_writes_o    = nb_writes_q;

endmodule

// File: tb/tb_multi_dataflow_tcdm_responder.sv
// Bench for two responder banks: one never stalls (base 0), one stalls ~50% (base 0x1000).
module tb_multi_dataflow_tcdm_responder;

  localparam int          NB    = 1024;
  localparam logic [31:0] BASE1 = 32'h1000;

  logic        clk, rst_n, clear;
  logic        req  [2];
  logic [31:0] add  [2];
  logic        wen  [2];
  logic [3:0]  be   [2];
  logic [31:0] wdat [2];
  logic        gnt  [2];
  logic [31:0] rdat [2];
  logic        rvld [2];
  logic        err  [2];
  logic [31:0] nrd  [2];
  logic [31:0] nwr  [2];

  multi_dataflow_tcdm_responder #(.STALL_EN(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req[0]), .tcdm_gnt_o(gnt[0]), .tcdm_add_i(add[0]), .tcdm_wen_i(wen[0]),
    .tcdm_be_i(be[0]), .tcdm_data_i(wdat[0]), .tcdm_r_data_o(rdat[0]),
    .tcdm_r_valid_o(rvld[0]), .err_o(err[0]), .nb_reads_o(nrd[0]), .nb_writes_o(nwr[0])
  );

  multi_dataflow_tcdm_responder #(.BASE_ADDR(BASE1), .STALL_EN(1'b1), .STALL_THRESH(8'd128)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .tcdm_req_i(req[1]), .tcdm_gnt_o(gnt[1]), .tcdm_add_i(add[1]), .tcdm_wen_i(wen[1]),
    .tcdm_be_i(be[1]), .tcdm_data_i(wdat[1]), .tcdm_r_data_o(rdat[1]),
    .tcdm_r_valid_o(rvld[1]), .err_o(err[1]), .nb_reads_o(nrd[1]), .nb_writes_o(nwr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus what each bank must present on its outputs.
  logic [31:0] m_mem   [2][NB];
  bit          m_known [2][NB];
  logic [15:0] m_lfsr  [2];
  bit          m_rv    [2];
  logic [31:0] m_rd    [2];
  bit          m_rd_ok [2];
  bit          m_err   [2];
  logic [31:0] m_nr    [2];
  logic [31:0] m_nw    [2];

  bit          c_g   [2];
  bit          c_wen [2];
  logic [31:0] c_add [2];
  logic [3:0]  c_be  [2];
  logic [31:0] c_dat [2];
  bit          c_clear;

  function automatic logic [31:0] base_of(input int i);
    return (i == 1) ? BASE1 : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i] = 16'hACE1; m_rv[i] = 0; m_rd[i] = 0; m_rd_ok[i] = 1;
      m_err[i] = 0; m_nr[i] = 0; m_nw[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      longint off = longint'(c_add[i]) - longint'(base_of(i));
      bit     inr = (off >= 0) && ((off / 4) < NB);
      int     idx = inr ? int'(off / 4) : 0;
      if (c_g[i] && !c_wen[i] && inr) begin
        for (int k = 0; k < 4; k++)
          if (c_be[i][k]) m_mem[i][idx][k*8 +: 8] = c_dat[i][k*8 +: 8];
        if (c_be[i] == 4'hF) m_known[i][idx] = 1;
      end
      if (c_clear) begin
        m_rv[i] = 0; m_err[i] = 0; m_nr[i] = 0; m_nw[i] = 0; m_lfsr[i] = 16'hACE1;
      end else begin
        m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 16'hB400 : 16'h0000);
        m_rv[i] = c_g[i];
        if (c_g[i]) begin
          if (c_wen[i]) m_nr[i] = m_nr[i] + 1; else m_nw[i] = m_nw[i] + 1;
          if (!inr) m_err[i] = 1;
          m_rd_ok[i] = 1;
          if (!c_wen[i]) m_rd[i] = 32'h0;
          else if (!inr) m_rd[i] = 32'hDEADBEEF;
          else begin m_rd[i] = m_mem[i][idx]; m_rd_ok[i] = m_known[i][idx]; end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk); #2;
      if (!rst_n) model_reset();
      for (int i = 0; i < 2; i++) begin
        c_g[i] = req[i] && !((i == 1) && (m_lfsr[i][7:0] < 8'd128));
        check($sformatf("gnt%0d", i), gnt[i], c_g[i]);
        check($sformatf("r_valid%0d", i), rvld[i], m_rv[i]);
        check($sformatf("err%0d", i), err[i], m_err[i]);
        check($sformatf("nb_reads%0d", i), nrd[i], m_nr[i]);
        check($sformatf("nb_writes%0d", i), nwr[i], m_nw[i]);
        if (m_rd_ok[i]) check($sformatf("r_data%0d", i), rdat[i], m_rd[i]);
        c_wen[i] = wen[i]; c_add[i] = add[i]; c_be[i] = be[i]; c_dat[i] = wdat[i];
      end
      c_clear = clear;
      @(posedge clk); #1;
      if (!rst_n) model_reset(); else model_step();
    end
  end

  // Called at a falling edge; returns at the falling edge after the grant with req still up.
  task automatic do_req(input int i, input bit rd, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int waited = 0;
    req[i] = 1'b1; wen[i] = rd; add[i] = a; be[i] = b; wdat[i] = d;
    #3;
    while (gnt[i] !== 1'b1) begin
      stall_cnt++; waited++;
      if (waited > 64) begin
        check("grant wait bound", gnt[i], 1'b1);
        break;
      end
      @(negedge clk); #3;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    rst_n = 1'b0; clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; wen[i] = 1; add[i] = 0; be[i] = 0; wdat[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("reset r_valid", rvld[0], 1'b0);
    check("reset r_data", rdat[0], 32'h0);
    check("reset counters", nrd[1] | nwr[1], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: full write then read back
    do_req(0, 0, 32'h0, 4'hF, 32'h11223344);
    do_req(0, 1, 32'h0, 4'hF, 32'h0);
    #1 check("T1 read data", rdat[0], 32'h11223344);
    check("T1 read valid", rvld[0], 1'b1);
    idle();

    // T2: partial write, read in the very next cycle
    do_req(0, 0, 32'h4, 4'hF, 32'h11223344);
    do_req(0, 0, 32'h4, 4'b0101, 32'hAABBCCDD);
    do_req(0, 1, 32'h4, 4'hF, 32'h0);
    #1 check("T2 merged data", rdat[0], 32'h11BB33DD);
    idle();

    // T3: 16 back-to-back reads
    pulse_clear();
    for (int k = 0; k < 16; k++) do_req(0, 0, 32'(4 * k), 4'hF, 32'h10000000 + 32'(k) * 32'h0101);
    run = 0;
    for (int k = 0; k < 16; k++) begin
      do_req(0, 1, 32'(4 * k), 4'hF, 32'h0);
      #1 run += int'(rvld[0]);
    end
    check("T3 valid run", run, 16);
    check("T3 nb_reads", nrd[0], 32'd16);
    check("T3 last data", rdat[0], 32'h10000F0F);
    idle();

    // T5: out-of-range accesses, sticky error, clear with a same-cycle write
    do_req(0, 1, 32'h1000, 4'hF, 32'h0);
    #1 check("T5 oor data", rdat[0], 32'hDEADBEEF);
    check("T5 err set", err[0], 1'b1);
    do_req(0, 0, 32'h2000, 4'hF, 32'h12345678);
    #1 check("T5 oor write resp", rdat[0], 32'h0);
    do_req(0, 0, 32'h8, 4'hF, 32'hCAFEF00D);
    do_req(0, 1, 32'h8, 4'hF, 32'h0);
    #1 check("T5 in-range after oor", rdat[0], 32'hCAFEF00D);
    check("T5 err sticky", err[0], 1'b1);
    clear = 1'b1;
    do_req(0, 0, 32'hC, 4'hF, 32'h0BADC0DE);
    clear = 1'b0;
    #1 check("T5 clear drops resp", rvld[0], 1'b0);
    check("T5 clear err", err[0], 1'b0);
    check("T5 clear reads", nrd[0], 32'h0);
    do_req(0, 1, 32'hC, 4'hF, 32'h0);
    #1 check("T5 write under clear", rdat[0], 32'h0BADC0DE);
    idle();

    // T4: stalling bank, random reads
    for (int k = 0; k < 64; k++) do_req(1, 0, BASE1 + 32'(4 * k), 4'hF, 32'hC0DE0000 + 32'(k));
    do_req(1, 1, BASE1 - 32'h4, 4'hF, 32'h0);
    #1 check("T4 below-base data", rdat[1], 32'hDEADBEEF);
    check("T4 below-base err", err[1], 1'b1);
    stall_cnt = 0;
    for (int n = 0; n < 1000; n++) do_req(1, 1, BASE1 + 32'(4 * $urandom_range(0, 63)), 4'hF, 32'h0);
    check("T4 stall ratio", (stall_cnt >= 500) && (stall_cnt <= 1500), 1'b1);
    check("T4 nb_reads", nrd[1], 32'd1001);
    check("T4 nb_writes", nwr[1], 32'd64);

    // T6: reset the cycle after a granted read
    do_req(1, 1, BASE1, 4'hF, 32'h0);
    rst_n = 1'b0; req[1] = 1'b0;
    #1 check("T6 valid killed", rvld[1], 1'b0);
    check("T6 data reset", rdat[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req[1] = 1'b1; wen[1] = 1'b1; add[1] = BASE1 + 32'h4; be[1] = 4'hF;
    #3 check("T6 seed no stall", gnt[1], 1'b1);
    @(negedge clk);
    #3 check("T6 seed next stall", gnt[1], 1'b0);
    do_req(1, 1, BASE1 + 32'h4, 4'hF, 32'h0);
    #1 check("T6 memory retained", rdat[1], 32'hC0DE0001);
    idle();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
